// File: rtl/vx_cache_flush_walker.sv
// Per-bank maintenance sequencer for the cache tag store.
// After reset it sweeps every set with the init strobe. On a flush request it
// walks every (set, way) pair toward the bank pipeline, then waits for every
// dirty eviction raised by that walk to be written back before it reports
// completion.
module vx_cache_flush_walker #(
   parameter int CACHE_SIZE = 1024,
   parameter int LINE_SIZE  = 16,
   parameter int NUM_BANKS  = 1,
   parameter int NUM_WAYS   = 1,
   localparam int SETS      = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
   localparam int SEL_W     = (SETS > 1) ? $clog2(SETS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_req_valid,
   output logic                flush_req_ready,
   output logic                init,
   output logic                flush_valid,
   input  logic                flush_ready,
   output logic [SEL_W-1:0]    line_sel,
   output logic [NUM_WAYS-1:0] flush_way_sel,
   input  logic                evict_valid,
   input  logic                wb_ack,
   output logic                flush_done_valid,
   input  logic                flush_done_ready,
   output logic                busy
);

   localparam int CNT_W = $clog2(SETS * NUM_WAYS + 1);
   localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam logic [SEL_W-1:0] LAST_SET = SEL_W'(SETS - 1);
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_WALK,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state, state_n;
   logic [SEL_W-1:0]   set_idx, set_n;
   logic [WAY_W-1:0]   way_idx, way_n;
   logic [CNT_W-1:0]   pend, pend_n;
   logic               evict_en;
   logic               ack_en;

   // Outstanding-writeback count: +1 per eviction, -1 per ack, saturating at
   // both ends so a protocol slip can never wrap the counter.
   function automatic logic [CNT_W-1:0] pend_update(input logic [CNT_W-1:0] cur,
                                                    input logic inc,
                                                    input logic dec);
      logic [CNT_W-1:0] res;
      res = cur;
      if (inc && !dec && (cur != {CNT_W{1'b1}})) begin
         res = cur + CNT_W'(1);
      end else if (dec && !inc && (cur != '0)) begin
         res = cur - CNT_W'(1);
      end
      return res;
   endfunction

   // Next-state logic; every output is decoded from registered state only.
   always_comb begin
      state_n          = state;
      set_n            = set_idx;
      way_n            = way_idx;
      init             = 1'b0;
      flush_req_ready  = 1'b0;
      flush_valid      = 1'b0;
      flush_done_valid = 1'b0;
      line_sel         = '0;
      flush_way_sel    = '0;
      busy             = (state != S_IDLE);

      // Evictions only count while a flush is in flight; acks never underflow.
      evict_en = evict_valid && ((state == S_WALK) || (state == S_DRAIN));
      ack_en   = wb_ack && (pend != '0);
      pend_n   = pend_update(pend, evict_en, ack_en);

      case (state)
         S_INIT: begin
            init     = 1'b1;
            line_sel = set_idx;
            if (set_idx == LAST_SET) begin
               state_n = S_IDLE;
               set_n   = '0;
            end else begin
               set_n = set_idx + SEL_W'(1);
            end
         end
         S_IDLE: begin
            flush_req_ready = 1'b1;
            if (flush_req_valid) begin
               state_n = S_WALK;
               set_n   = '0;
               way_n   = '0;
            end
         end
         S_WALK: begin
            flush_valid   = 1'b1;
            line_sel      = set_idx;
            flush_way_sel = NUM_WAYS'(1) << way_idx;
            if (flush_ready) begin
               // Way is the inner index, set the outer one.
               if (way_idx == LAST_WAY) begin
                  way_n = '0;
                  if (set_idx == LAST_SET) begin
                     state_n = S_DRAIN;
                     set_n   = '0;
                  end else begin
                     set_n = set_idx + SEL_W'(1);
                  end
               end else begin
                  way_n = way_idx + WAY_W'(1);
               end
            end
         end
         S_DRAIN: begin
            // An eviction in this very cycle still has a writeback to wait for.
            if ((pend == '0) && !evict_valid) begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            flush_done_valid = 1'b1;
            if (flush_done_ready) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_INIT;
            set_n   = '0;
            way_n   = '0;
         end
      endcase
   end

   // State register; reset restarts the init sweep and forgets pending writebacks.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_INIT;
         set_idx <= '0;
         way_idx <= '0;
         pend    <= '0;
      end else begin
         state   <= state_n;
         set_idx <= set_n;
         way_idx <= way_n;
         pend    <= pend_n;
      end
   end

   // Simulation-only protocol checks on the eviction/writeback pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(wb_ack && (pend == '0)))
            else $warning("wb_ack with no pending writeback ignored");
         assert (!(evict_valid && (state != S_WALK) && (state != S_DRAIN)))
            else $warning("evict_valid outside a flush ignored");
      end
   end

endmodule

// File: tb/tb_vx_cache_flush_walker.sv
// Directed bench for vx_cache_flush_walker with SETS=32, NUM_WAYS=2.
// Expected flush beats and delayed writeback acks are queued when stimulus is
// driven and consumed as the DUT produces beats.
module tb_vx_cache_flush_walker;

   localparam int SETS = 32;
   localparam int WAYS = 2;
   localparam int BEATS = SETS * WAYS;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush_req_valid;
   logic       flush_req_ready;
   logic       init;
   logic       flush_valid;
   logic       flush_ready;
   logic [4:0] line_sel;
   logic [1:0] flush_way_sel;
   logic       evict_valid;
   logic       wb_ack;
   logic       flush_done_valid;
   logic       flush_done_ready;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   int exp_set_q[$];
   int exp_way_q[$];

   vx_cache_flush_walker #(
      .CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(WAYS)
   ) dut (
      .clk(clk), .reset(reset),
      .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
      .init(init), .flush_valid(flush_valid), .flush_ready(flush_ready),
      .line_sel(line_sel), .flush_way_sel(flush_way_sel),
      .evict_valid(evict_valid), .wb_ack(wb_ack),
      .flush_done_valid(flush_done_valid), .flush_done_ready(flush_done_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expects the DUT to be in init cycle 0; walks the whole init sweep.
   task automatic init_phase();
      for (int c = 0; c < SETS; c++) begin
         chk("init_strobe", init, 1);
         chk("init_line_sel", line_sel, c);
         chk("init_req_ready", flush_req_ready, 0);
         chk("init_busy", busy, 1);
         chk("init_done_valid", flush_done_valid, 0);
         tick();
      end
      chk("idle_req_ready", flush_req_ready, 1);
      chk("idle_busy", busy, 0);
   endtask

   // One flush from IDLE. rnd: random flush_ready. ev: eviction pattern.
   // abort_beat >= 0: assert reset while that beat is presented and return.
   task automatic run_flush(input bit rnd, input int ev, input int abort_beat);
      int ev_list[$];
      int ack_q[$];
      int beats, last_c, ok_c, mp;
      bit stalled, done_seen;
      int pl, pw;
      if (ev == 1) ev_list = '{3, 10, 23, 40, 60};
      else if (ev == 2) ev_list = '{2, 4, 6};
      chk("req_ready_before_accept", flush_req_ready, 1);
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            exp_set_q.push_back(s);
            exp_way_q.push_back(1 << w);
         end
      end
      flush_req_valid = 1'b1;
      tick();
      flush_req_valid = 1'b0;
      beats = 0; last_c = -1; ok_c = -1; mp = 0;
      stalled = 1'b0; done_seen = 1'b0; pl = 0; pw = 0;
      for (int c = 0; c < 400; c++) begin
         if (c == abort_beat) begin
            chk("pend_before_abort", int'(dut.pend), mp);
            flush_ready = 1'b0; evict_valid = 1'b0; wb_ack = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            exp_set_q.delete();
            exp_way_q.delete();
            return;
         end
         flush_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         evict_valid = 1'b0;
         if (ev_list.size() > 0 && ev_list[0] == c) begin
            evict_valid = 1'b1;
            void'(ev_list.pop_front());
            ack_q.push_back(c + 20);
         end
         wb_ack = 1'b0;
         if (ack_q.size() > 0 && ack_q[0] == c) begin
            wb_ack = 1'b1;
            void'(ack_q.pop_front());
         end
         chk("pend", int'(dut.pend), mp);
         if (last_c >= 0 && ok_c < 0 && mp == 0 && !evict_valid) ok_c = c;
         chk("done_valid", flush_done_valid, (ok_c >= 0 && c > ok_c) ? 1 : 0);
         chk("walk_busy", busy, 1);
         if (flush_valid) begin
            if (stalled) begin
               chk("stall_line_stable", line_sel, pl);
               chk("stall_way_stable", flush_way_sel, pw);
            end
            if (flush_ready) begin
               if (exp_set_q.size() == 0) begin
                  chk("extra_beat", 1, 0);
               end else begin
                  chk("beat_set", line_sel, exp_set_q.pop_front());
                  chk("beat_way", flush_way_sel, exp_way_q.pop_front());
               end
               beats++;
               if (beats == BEATS) last_c = c;
            end
            stalled = !flush_ready;
            pl = line_sel;
            pw = flush_way_sel;
         end else begin
            stalled = 1'b0;
            chk("way_sel_idle", flush_way_sel, 0);
         end
         if (flush_done_valid) begin
            done_seen = 1'b1;
            break;
         end
         if (evict_valid && !wb_ack) mp++;
         else if (wb_ack && !evict_valid && mp > 0) mp--;
         tick();
      end
      flush_ready = 1'b0; evict_valid = 1'b0; wb_ack = 1'b0;
      chk("done_seen", done_seen, 1);
      chk("beats_total", beats, BEATS);
      chk("done_pend_zero", int'(dut.pend), 0);
      flush_done_ready = 1'b1;
      tick();
      flush_done_ready = 1'b0;
      chk("after_done_req_ready", flush_req_ready, 1);
      chk("after_done_valid", flush_done_valid, 0);
      chk("after_done_busy", busy, 0);
   endtask

   initial begin
      reset = 1'b1;
      flush_req_valid = 1'b1;
      flush_ready = 1'b0;
      evict_valid = 1'b0;
      wb_ack = 1'b0;
      flush_done_ready = 1'b0;
      repeat (2) tick();
      chk("rst_init", init, 1);
      chk("rst_flush_valid", flush_valid, 0);
      chk("rst_req_ready", flush_req_ready, 0);
      chk("rst_done_valid", flush_done_valid, 0);
      chk("rst_busy", busy, 1);
      chk("rst_line_sel", line_sel, 0);
      chk("rst_way_sel", flush_way_sel, 0);
      chk("rst_pend", int'(dut.pend), 0);
      reset = 1'b0;
      // Request held since reset: refused through init, taken in first IDLE cycle.
      init_phase();
      run_flush(1'b0, 0, -1);
      // Back-to-back request in the first IDLE cycle after DONE, random stalls.
      run_flush(1'b1, 0, -1);
      run_flush(1'b0, 1, -1);
      run_flush(1'b0, 2, 10);
      chk("abort_init", init, 1);
      chk("abort_line_sel", line_sel, 0);
      chk("abort_pend", int'(dut.pend), 0);
      chk("abort_flush_valid", flush_valid, 0);
      chk("abort_done_valid", flush_done_valid, 0);
      init_phase();
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      chk("stray_ack_pend", int'(dut.pend), 0);
      chk("stray_ack_req_ready", flush_req_ready, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
